// File: rtl/cache_pkg.sv
// Shared L1D line geometry and the refill sequencer state encoding.
package cache_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int LINE_BYTES = 64;
   localparam int BEATS      = LINE_BYTES * 8 / DATA_WIDTH;
   localparam int BEAT_W     = $clog2(BEATS);
   localparam int OFFSET_W   = $clog2(LINE_BYTES);

   typedef enum logic [2:0] {
      IDLE,
      WB_REQ,
      WB_RD,
      WB_SEND,
      WB_RESP,
      RF_REQ,
      RF_DATA,
      DONE
   } refill_state_t;

endpackage

// File: rtl/l1d_refill_ctrl.sv
// L1D miss sequencer: optional dirty-victim write-back, then beat-by-beat line refill.
// Clean zero-wait miss: ack at cycle 0, request at 1, beats 2..17, refill_done at 18; stalls follow memory ready.
module l1d_refill_ctrl #(
   parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH  = cache_pkg::DATA_WIDTH,
   parameter int LINE_BYTES  = cache_pkg::LINE_BYTES,
   localparam int BEATS      = LINE_BYTES * 8 / DATA_WIDTH,
   localparam int BEAT_W     = $clog2(BEATS),
   localparam int OFFSET_W   = $clog2(LINE_BYTES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_req,
   input  logic [ADDR_WIDTH-1:0] miss_addr,
   input  logic                  victim_dirty,
   input  logic [ADDR_WIDTH-1:0] victim_addr,
   output logic                  miss_ack,
   output logic                  busy,
   output logic                  refill_done,
   output logic                  protocol_err,
   output logic                  arr_rd_en,
   output logic [BEAT_W-1:0]     arr_rd_beat,
   input  logic [DATA_WIDTH-1:0] arr_rd_data,
   output logic                  arr_wr_en,
   output logic [BEAT_W-1:0]     arr_wr_beat,
   output logic [DATA_WIDTH-1:0] arr_wr_data,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_write,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   output logic                  mem_wdata_valid,
   input  logic                  mem_wdata_ready,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wlast,
   input  logic                  mem_wresp_valid,
   input  logic                  mem_rdata_valid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rlast
);

   import cache_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((64'd1 << OFFSET_W) - 64'd1);
   localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);

   refill_state_t         state_q, state_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] wbuf_q;
   logic                  wbuf_load_q;
   logic [ADDR_WIDTH-1:0] miss_line_q;
   logic [ADDR_WIDTH-1:0] victim_line_q;

   assign busy         = (state_q != IDLE);
   assign protocol_err = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         beat_q        <= '0;
         err_q         <= 1'b0;
         wbuf_q        <= '0;
         wbuf_load_q   <= 1'b0;
         miss_line_q   <= '0;
         victim_line_q <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         err_q       <= err_d;
         // Array data lands one cycle after the read; hold it for as long as the write beat stalls.
         wbuf_load_q <= (state_q == WB_RD);
         if (wbuf_load_q) begin
            wbuf_q <= arr_rd_data;
         end
         if (miss_ack) begin
            miss_line_q   <= miss_addr & ~LINE_MASK;
            victim_line_q <= victim_addr & ~LINE_MASK;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      beat_d          = beat_q;
      err_d           = err_q;
      miss_ack        = 1'b0;
      refill_done     = 1'b0;
      arr_rd_en       = 1'b0;
      arr_rd_beat     = '0;
      arr_wr_en       = 1'b0;
      arr_wr_beat     = '0;
      arr_wr_data     = '0;
      mem_req_valid   = 1'b0;
      mem_req_write   = 1'b0;
      mem_req_addr    = '0;
      mem_wdata_valid = 1'b0;
      mem_wdata       = '0;
      mem_wlast       = 1'b0;

      case (state_q)
         IDLE: begin
            if (miss_req && !rst) begin
               miss_ack = 1'b1;
               state_d  = victim_dirty ? WB_REQ : RF_REQ;
            end
         end
         WB_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_req_addr  = victim_line_q;
            if (mem_req_ready) begin
               beat_d  = '0;
               state_d = WB_RD;
            end
         end
         WB_RD: begin
            arr_rd_en   = 1'b1;
            arr_rd_beat = beat_q;
            state_d     = WB_SEND;
         end
         WB_SEND: begin
            mem_wdata_valid = 1'b1;
            mem_wdata       = wbuf_load_q ? arr_rd_data : wbuf_q;
            mem_wlast       = (beat_q == LAST_BEAT);
            if (mem_wdata_ready) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = WB_RESP;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
                  state_d = WB_RD;
               end
            end
         end
         WB_RESP: begin
            if (mem_wresp_valid) begin
               state_d = RF_REQ;
            end
         end
         RF_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = miss_line_q;
            if (mem_req_ready) begin
               beat_d  = '0;
               state_d = RF_DATA;
            end
         end
         RF_DATA: begin
            if (mem_rdata_valid) begin
               arr_wr_en   = 1'b1;
               arr_wr_beat = beat_q;
               arr_wr_data = mem_rdata;
               // Burst length is fixed by the counter; rlast is only cross-checked.
               if (mem_rlast != (beat_q == LAST_BEAT)) begin
                  err_d = 1'b1;
               end
               if (beat_q == LAST_BEAT) begin
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         DONE: begin
            refill_done = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_l1d_refill_ctrl.sv
// Directed bench for l1d_refill_ctrl: memory/array responder, event logger and hand-computed checks.
module tb_l1d_refill_ctrl;
   import cache_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  miss_req;
   logic [ADDR_WIDTH-1:0] miss_addr;
   logic                  victim_dirty;
   logic [ADDR_WIDTH-1:0] victim_addr;
   logic                  miss_ack, busy, refill_done, protocol_err;
   logic                  arr_rd_en;
   logic [BEAT_W-1:0]     arr_rd_beat;
   logic [DATA_WIDTH-1:0] arr_rd_data;
   logic                  arr_wr_en;
   logic [BEAT_W-1:0]     arr_wr_beat;
   logic [DATA_WIDTH-1:0] arr_wr_data;
   logic                  mem_req_valid, mem_req_ready, mem_req_write;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic                  mem_wdata_valid, mem_wdata_ready, mem_wlast;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_wresp_valid, mem_rdata_valid, mem_rlast;
   logic [DATA_WIDTH-1:0] mem_rdata;

   l1d_refill_ctrl dut (
      .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
      .victim_dirty(victim_dirty), .victim_addr(victim_addr),
      .miss_ack(miss_ack), .busy(busy), .refill_done(refill_done), .protocol_err(protocol_err),
      .arr_rd_en(arr_rd_en), .arr_rd_beat(arr_rd_beat), .arr_rd_data(arr_rd_data),
      .arr_wr_en(arr_wr_en), .arr_wr_beat(arr_wr_beat), .arr_wr_data(arr_wr_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
      .mem_wdata(mem_wdata), .mem_wlast(mem_wlast), .mem_wresp_valid(mem_wresp_valid),
      .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Responder knobs, written only by the main sequence.
   int   stall_cfg = 0;
   logic toggle_en = 1'b0, gap_en = 1'b0, stray_en = 1'b0;
   int   bad_beat  = -1;

   // Event log, written only by the negedge monitor.
   int cyc = 0, ack_n = 0, done_n = 0, wresp_n = 0, req_n = 0, wd_n = 0, wr_n = 0;
   int hold_err_n = 0, hold_obs_n = 0, rd_req_n = 0, rf_start_n = 0, wlast_n = 0;
   int ack_cyc = 0, done_cyc = 0, ack_at_done = 0;
   logic                  req_wr_log   [0:63];
   logic [ADDR_WIDTH-1:0] req_addr_log [0:63];
   int                    req_wresp_log[0:63];
   int                    req_cyc_log  [0:63];
   logic [DATA_WIDTH-1:0] wd_data_log  [0:255];
   logic                  wd_last_log  [0:255];
   logic [BEAT_W-1:0]     wr_beat_log  [0:255];
   logic [DATA_WIDTH-1:0] wr_data_log  [0:255];
   logic [BEAT_W-1:0]     rd_beat_pend = '0;
   logic                  req_stalled = 1'b0, req_prev_wr = 1'b0, wd_stalled = 1'b0, wd_prev_last = 1'b0;
   logic [ADDR_WIDTH-1:0] req_prev_addr = '0;
   logic [DATA_WIDTH-1:0] wd_prev = '0;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
         req_stalled = 1'b0;
         wd_stalled  = 1'b0;
      end else begin
         if (miss_ack) begin ack_n++; ack_cyc = cyc; end
         if (req_stalled) begin
            hold_obs_n++;
            if (!(mem_req_valid && mem_req_addr == req_prev_addr && mem_req_write == req_prev_wr)) hold_err_n++;
         end
         if (wd_stalled) begin
            hold_obs_n++;
            if (!(mem_wdata_valid && mem_wdata == wd_prev && mem_wlast == wd_prev_last)) hold_err_n++;
         end
         req_stalled = mem_req_valid && !mem_req_ready;
         req_prev_addr = mem_req_addr; req_prev_wr = mem_req_write;
         wd_stalled = mem_wdata_valid && !mem_wdata_ready;
         wd_prev = mem_wdata; wd_prev_last = mem_wlast;
         if (mem_wresp_valid) wresp_n++;
         if (mem_req_valid && mem_req_ready && req_n < 64) begin
            req_wr_log[req_n] = mem_req_write; req_addr_log[req_n] = mem_req_addr;
            req_wresp_log[req_n] = wresp_n; req_cyc_log[req_n] = cyc;
            req_n++;
            if (!mem_req_write) rf_start_n++;
         end
         if (mem_wdata_valid && mem_wdata_ready && wd_n < 256) begin
            wd_data_log[wd_n] = mem_wdata; wd_last_log[wd_n] = mem_wlast; wd_n++;
            if (mem_wlast) wlast_n++;
         end
         if (arr_rd_en) begin rd_beat_pend = arr_rd_beat; rd_req_n++; end
         if (arr_wr_en && wr_n < 256) begin
            wr_beat_log[wr_n] = arr_wr_beat; wr_data_log[wr_n] = arr_wr_data; wr_n++;
         end
         if (refill_done) begin done_n++; done_cyc = cyc; ack_at_done = ack_n; end
      end
   end

   // Memory and data-array responder; drives after the main sequence within each cycle.
   int   rd_served = 0, rf_seen = 0, wl_seen = 0, req_wait = 0, rf_beat = 0, wresp_delay = 0;
   logic rf_active = 1'b0, gap_phase = 1'b0;

   initial forever begin
      @(posedge clk);
      #2;
      if (rst !== 1'b0) begin
         mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_wresp_valid = 1'b0;
         mem_rdata_valid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0; arr_rd_data = '0;
         rf_active = 1'b0; wresp_delay = 0; req_wait = 0;
         rd_served = rd_req_n; rf_seen = rf_start_n; wl_seen = wlast_n;
      end else begin
         if (mem_req_valid) begin
            mem_req_ready = (req_wait >= stall_cfg);
            req_wait = mem_req_ready ? 0 : req_wait + 1;
         end else begin
            mem_req_ready = 1'b0;
            req_wait = 0;
         end
         mem_wdata_ready = toggle_en ? !mem_wdata_ready : 1'b1;
         if (rd_req_n != rd_served) begin
            arr_rd_data = {28'hA000000, rd_beat_pend};
            rd_served = rd_req_n;
         end else begin
            arr_rd_data = 32'hDEAD_BEEF;
         end
         if (wlast_n != wl_seen) begin wl_seen = wlast_n; wresp_delay = 3; end
         mem_wresp_valid = 1'b0;
         if (wresp_delay > 0) begin
            wresp_delay--;
            if (wresp_delay == 0) mem_wresp_valid = 1'b1;
         end
         if (rf_start_n != rf_seen) begin
            rf_seen = rf_start_n; rf_active = 1'b1; rf_beat = 0; gap_phase = 1'b0;
         end
         mem_rdata_valid = 1'b0; mem_rlast = 1'b0; mem_rdata = 32'h5555_5555;
         if (rf_active) begin
            if (gap_en && gap_phase) begin
               gap_phase = 1'b0;
            end else begin
               mem_rdata_valid = 1'b1;
               mem_rdata = rf_beat;
               mem_rlast = (rf_beat == 15) != (rf_beat == bad_beat);
               if (rf_beat == 15) rf_active = 1'b0;
               rf_beat++;
               gap_phase = 1'b1;
            end
         end
         if (stray_en) begin
            mem_rdata_valid = 1'b1; mem_rlast = 1'b1; mem_wresp_valid = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_miss(input logic [31:0] a, input logic d, input logic [31:0] v, output bit ok);
      int base;
      base = ack_n;
      miss_req = 1'b1; miss_addr = a; victim_dirty = d; victim_addr = v;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ack_n != base) begin ok = 1'b1; break; end
      end
      miss_req = 1'b0;
   endtask

   task automatic wait_done(input int base, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (done_n > base) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   function automatic int wr_seq_ok(input int base);
      int n = 0;
      for (int i = 0; i < 16; i++)
         if (int'(wr_beat_log[base+i]) == i && wr_data_log[base+i] == 32'(i)) n++;
      return n;
   endfunction

   function automatic int wd_seq_ok(input int base);
      int n = 0;
      for (int i = 0; i < 16; i++)
         if (wd_data_log[base+i] == (32'hA000_0000 | 32'(i)) && wd_last_log[base+i] == (i == 15)) n++;
      return n;
   endfunction

   int rb, wb, db, db2, ab, wdb, wrb, hb, heb;
   bit ok;

   initial begin
      rst = 1'b1; miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0; victim_addr = '0;
      repeat (3) tick();
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_ack", miss_ack, 0);
      chk_eq("rst_done", refill_done, 0);
      chk_eq("rst_err", protocol_err, 0);
      chk_eq("rst_req_valid", mem_req_valid, 0);
      rst = 1'b0;
      tick();

      // Clean miss, zero-wait memory.
      rb = req_n; wb = wr_n; db = done_n;
      start_miss(32'h0000_1234, 1'b0, 32'h0, ok);
      chk_eq("t1_ack", ok, 1);
      wait_done(db, ok);
      chk_eq("t1_done", ok, 1);
      chk_eq("t1_req_n", req_n - rb, 1);
      chk_eq("t1_req_write", req_wr_log[rb], 0);
      chk_eq("t1_req_addr", req_addr_log[rb], 32'h0000_1200);
      chk_eq("t1_req_latency", req_cyc_log[rb] - ack_cyc, 1);
      chk_eq("t1_done_latency", done_cyc - ack_cyc, 18);
      chk_eq("t1_wr_n", wr_n - wb, 16);
      chk_eq("t1_wr_seq", wr_seq_ok(wb), 16);
      repeat (2) tick();
      chk_eq("t1_done_pulses", done_n - db, 1);
      chk_eq("t1_idle", busy, 0);

      // Dirty miss: write-back first, refill requested only after the write response.
      rb = req_n; wb = wr_n; db = done_n; wdb = wd_n; wrb = wresp_n;
      start_miss(32'h0000_2000, 1'b1, 32'h0000_8040, ok);
      chk_eq("t2_ack", ok, 1);
      wait_done(db, ok);
      chk_eq("t2_done", ok, 1);
      chk_eq("t2_req_n", req_n - rb, 2);
      chk_eq("t2_wb_write", req_wr_log[rb], 1);
      chk_eq("t2_wb_addr", req_addr_log[rb], 32'h0000_8040);
      chk_eq("t2_wd_n", wd_n - wdb, 16);
      chk_eq("t2_wd_seq", wd_seq_ok(wdb), 16);
      chk_eq("t2_rf_write", req_wr_log[rb+1], 0);
      chk_eq("t2_rf_addr", req_addr_log[rb+1], 32'h0000_2000);
      chk_eq("t2_rf_after_wresp", req_wresp_log[rb+1] - wrb, 1);
      chk_eq("t2_wr_seq", wr_seq_ok(wb), 16);

      // Backpressure on request, write data and gapped refill data.
      stall_cfg = 5; toggle_en = 1'b1; gap_en = 1'b1;
      rb = req_n; wb = wr_n; db = done_n; wdb = wd_n; hb = hold_obs_n; heb = hold_err_n;
      start_miss(32'h0000_3FFF, 1'b1, 32'h0000_C0FF, ok);
      chk_eq("t3_ack", ok, 1);
      wait_done(db, ok);
      chk_eq("t3_done", ok, 1);
      chk_eq("t3_stall_seen", (hold_obs_n - hb) >= 10, 1);
      chk_eq("t3_hold_errors", hold_err_n - heb, 0);
      chk_eq("t3_wb_addr", req_addr_log[rb], 32'h0000_C0C0);
      chk_eq("t3_rf_addr", req_addr_log[rb+1], 32'h0000_3FC0);
      chk_eq("t3_wd_n", wd_n - wdb, 16);
      chk_eq("t3_wd_seq", wd_seq_ok(wdb), 16);
      chk_eq("t3_wr_n", wr_n - wb, 16);
      chk_eq("t3_wr_seq", wr_seq_ok(wb), 16);
      stall_cfg = 0; toggle_en = 1'b0; gap_en = 1'b0;
      tick();

      // miss_req held while busy; early rlast on beat 7.
      bad_beat = 7;
      ab = ack_n; wb = wr_n; db = done_n;
      miss_req = 1'b1; miss_addr = 32'h0000_4000; victim_dirty = 1'b0; victim_addr = '0;
      wait_done(db, ok);
      chk_eq("t4_done", ok, 1);
      chk_eq("t4_acks_while_busy", ack_at_done - ab, 1);
      chk_eq("t4_err", protocol_err, 1);
      chk_eq("t4_wr_n", wr_n - wb, 16);
      bad_beat = -1;
      tick();
      chk_eq("t4_reack", ack_n - ab, 2);
      chk_eq("t4_reack_cycle", ack_cyc - done_cyc, 1);
      miss_req = 1'b0;
      wait_done(db + 1, ok);
      chk_eq("t4_done2", ok, 1);
      chk_eq("t4_err_sticky", protocol_err, 1);

      // Reset in the middle of a refill burst.
      wb = wr_n;
      start_miss(32'h0000_5000, 1'b0, 32'h0, ok);
      chk_eq("t5_ack", ok, 1);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (wr_n - wb >= 6) begin ok = 1'b1; break; end
         tick();
      end
      chk_eq("t5_reach_beat6", ok, 1);
      rst = 1'b1;
      tick();
      chk_eq("t5_busy", busy, 0);
      chk_eq("t5_err", protocol_err, 0);
      chk_eq("t5_ctl", {miss_ack, refill_done, arr_rd_en, arr_rd_beat, arr_wr_en, arr_wr_beat,
                        mem_req_valid, mem_req_write, mem_wdata_valid, mem_wlast}, 0);
      chk_eq("t5_data", {arr_wr_data, mem_wdata}, 0);
      chk_eq("t5_addr", mem_req_addr, 0);
      rst = 1'b0;
      tick();
      rb = req_n; wb = wr_n; db = done_n;
      start_miss(32'h0000_6010, 1'b0, 32'h0, ok);
      wait_done(db, ok);
      chk_eq("t5_fresh_done", ok, 1);
      chk_eq("t5_fresh_addr", req_addr_log[rb], 32'h0000_6000);
      chk_eq("t5_fresh_wr_seq", wr_seq_ok(wb), 16);
      chk_eq("t5_fresh_err", protocol_err, 0);
      tick();

      // Stray memory responses while idle.
      rb = req_n; wb = wr_n; db2 = done_n;
      stray_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_eq("t6_wr_en", arr_wr_en, 0);
      end
      stray_en = 1'b0;
      tick();
      chk_eq("t6_busy", busy, 0);
      chk_eq("t6_wr_n", wr_n - wb, 0);
      chk_eq("t6_req_n", req_n - rb, 0);
      chk_eq("t6_done_n", done_n - db2, 0);
      chk_eq("t6_err", protocol_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule
